// File: rtl/warp_issue_arbiter_if.sv
// Purpose: issue-side bundle of warp_issue_arbiter (warp inputs, issue handshake, busy-set and array ownership).
// Latency: none; wiring only.
// Backpressure: issue_valid/issue_ready handshake carried between the master (arbiter) and slave (decode/LSU side).
interface warp_issue_arbiter_if;
  logic        sched_en;
  logic [3:0]  ready_warps;
  logic [15:0] warp_opcode;
  logic [7:0]  warp_array_id;
  logic [15:0] warp_mask;
  logic        issue_ready;
  logic        array_done;
  logic [1:0]  array_done_id;
  logic [1:0]  select_warp;
  logic        issue_valid;
  logic        busy_en;
  logic [1:0]  warp_num_busy;
  logic [3:0]  threads_mask_busy;
  logic [3:0]  array_busy;
  logic        push_active;

  // Arbiter side: consumes warp state and issue_ready, produces the grant and busy strobes.
  modport master (
    input  sched_en, ready_warps, warp_opcode, warp_array_id, warp_mask,
    input  issue_ready, array_done, array_done_id,
    output select_warp, issue_valid, busy_en, warp_num_busy, threads_mask_busy,
    output array_busy, push_active
  );

  // Environment side: drives warp state and issue_ready, observes the grant.
  modport slave (
    output sched_en, ready_warps, warp_opcode, warp_array_id, warp_mask,
    output issue_ready, array_done, array_done_id,
    input  select_warp, issue_valid, busy_en, warp_num_busy, threads_mask_busy,
    input  array_busy, push_active
  );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Purpose: round-robin issue arbiter over 4 warps with systolic-array push lock; define WARP_ARB_AGING_EN for skip-count aging priority.
// Latency: ready_warps sampled in cycle N gives issue_valid in N+1; at most one issue every 2 cycles.
// Backpressure: grant and latched fields held in ISSUE until issue_ready; busy_en pulses only in the accept cycle.
module warp_issue_arbiter #(
  parameter int         NUM_WARPS  = 4,
  parameter int         MASK_WIDTH = 4,
  parameter int         NUM_ARRAYS = 4,
  parameter logic [3:0] OP_PUSH    = 4'b1010
`ifdef WARP_ARB_AGING_EN
  ,
  parameter int         AGE_LIMIT  = 7
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  warp_issue_arbiter_if.master io
);

  typedef enum logic {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  // Latched grant and the fields captured with it.
  logic [1:0]              sel_q;
  logic [MASK_WIDTH-1:0]   mask_q;
  logic [3:0]              op_q;
  logic [1:0]              aid_q;
  logic [1:0]              last_grant;

  logic [NUM_ARRAYS-1:0]   array_busy_q;
  logic [NUM_ARRAYS-1:0]   array_busy_nxt;

  // Per-warp views of the packed warp buses.
  logic [3:0]              op_w   [NUM_WARPS];
  logic [1:0]              aid_w  [NUM_WARPS];
  logic [MASK_WIDTH-1:0]   mask_w [NUM_WARPS];

  logic [NUM_WARPS-1:0]    elig;
  logic [NUM_WARPS-1:0]    cand;
  logic [1:0]              pick;
  logic [1:0]              idx;
  logic                    pick_vld;

  logic                    grant;
  logic                    accept;
  logic                    issue_vld;
  logic                    push_set;

  // Unpack per-warp opcode, array id and mask from the flat buses.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      op_w[w]   = io.warp_opcode[4*w +: 4];
      aid_w[w]  = io.warp_array_id[2*w +: 2];
      mask_w[w] = io.warp_mask[MASK_WIDTH*w +: MASK_WIDTH];
    end
  end

  // A warp is eligible when ready and not a push aimed at an array still owned by an earlier push.
  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = io.ready_warps[w] &
                ~((io.warp_opcode[4*w +: 4] == OP_PUSH) &
                  array_busy_q[io.warp_array_id[2*w +: 2]]);
    end
  end

`ifdef WARP_ARB_AGING_EN
  logic [2:0]           skip_cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] aged;

  // Warps skipped AGE_LIMIT times or more form a priority class of their own.
  always_comb begin
    aged = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      aged[w] = elig[w] & (skip_cnt[w] >= 3'(AGE_LIMIT));
    end
  end

  assign cand = (|aged) ? aged : elig;

  // Count decisions a warp lost while eligible; a grant restarts its count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) skip_cnt[w] <= 3'd0;
    end else if (grant) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (2'(w) == pick) begin
          skip_cnt[w] <= 3'd0;
        end else if (elig[w] && (skip_cnt[w] != 3'd7)) begin
          skip_cnt[w] <= skip_cnt[w] + 3'd1;
        end
      end
    end
  end
`else
  assign cand = elig;
`endif

  // Round-robin search starting one past the last accepted warp.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = last_grant + 2'(i);
      if (!pick_vld && cand[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // State register; reset forces ARB so issue_valid drops asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accept    = 1'b0;
    issue_vld = 1'b0;
    case (state)
      ARB: begin
        if (io.sched_en && pick_vld) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_vld = 1'b1;
        if (io.issue_ready) begin
          accept    = 1'b1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Capture the winning warp's fields at grant; they stay frozen through ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q  <= '0;
      mask_q <= '0;
      op_q   <= '0;
      aid_q  <= '0;
    end else if (grant) begin
      sel_q  <= pick;
      mask_q <= mask_w[pick];
      op_q   <= op_w[pick];
      aid_q  <= aid_w[pick];
    end
  end

  // Round-robin pointer advances only when the downstream accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 2'd3;
    end else if (accept) begin
      last_grant <= sel_q;
    end
  end

  assign push_set = accept & (op_q == OP_PUSH);

  // Array ownership: done clears, an accepted push sets; set is applied last so it wins a same-id collision.
  always_comb begin
    array_busy_nxt = array_busy_q;
    if (io.array_done) array_busy_nxt[io.array_done_id] = 1'b0;
    if (push_set)      array_busy_nxt[aid_q]            = 1'b1;
  end

  // Array ownership register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      array_busy_q <= '0;
    end else begin
      array_busy_q <= array_busy_nxt;
    end
  end

  assign io.select_warp       = sel_q;
  assign io.issue_valid       = issue_vld;
  assign io.busy_en           = accept;
  assign io.warp_num_busy     = accept ? sel_q : 2'd0;
  assign io.threads_mask_busy = accept ? mask_q : '0;
  assign io.array_busy        = array_busy_q;
  assign io.push_active       = |array_busy_q;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Purpose: self-checking bench for warp_issue_arbiter (vector table plus scoreboard of busy-set strobes).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: issue_ready driven per vector; hand sequences cover reset mid-ISSUE and aging.
module tb_warp_issue_arbiter;

  localparam logic [15:0] MASKS = 16'hF731;

  typedef struct {
    bit          rst;
    bit          sched;
    logic [3:0]  rdy;
    bit          ir;
    bit          done;
    logic [1:0]  did;
    logic [15:0] op;
    logic [7:0]  aid;
    bit          e_iv;
    logic [1:0]  e_sel;
    bit          e_busy;
    logic [3:0]  e_ab;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       tv[$];
  logic [5:0] sb_q[$];

  warp_issue_arbiter_if bus ();

  warp_issue_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mask_of(input logic [1:0] w);
    logic [15:0] m;
    m = MASKS;
    return m[4*w +: 4];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit sched, input logic [3:0] rdy, input bit ir,
                     input bit done, input logic [1:0] did, input logic [15:0] op,
                     input logic [7:0] aid, input bit e_iv, input logic [1:0] e_sel,
                     input bit e_busy, input logic [3:0] e_ab);
    vec_t v;
    v.rst = rst; v.sched = sched; v.rdy = rdy; v.ir = ir; v.done = done; v.did = did;
    v.op = op; v.aid = aid; v.e_iv = e_iv; v.e_sel = e_sel; v.e_busy = e_busy; v.e_ab = e_ab;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.ready_warps = 4'h0;
    bus.array_done  = 1'b0;
    bus.issue_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Request one issue with the given ready set and expect warp exp to be granted and accepted.
  task automatic issue_one(input logic [3:0] rdy, input logic [1:0] exp, input string name);
    bit got;
    got = 1'b0;
    sb_q.push_back({exp, mask_of(exp)});
    bus.ready_warps = rdy;
    bus.issue_ready = 1'b1;
    bus.sched_en    = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.issue_valid === 1'b1) begin
        got = 1'b1;
        check(name, bus.select_warp, exp);
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    bus.ready_warps = 4'h0;
  endtask

  // Scoreboard: every busy-set strobe must match the oldest expected grant.
  always @(negedge clk) begin
    logic [5:0] e;
    if (bus.busy_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_spurious: busy_en with warp %0d, none expected", bus.warp_num_busy);
      end else begin
        e = sb_q.pop_front();
        check("sb_busy_set", {bus.warp_num_busy, bus.threads_mask_busy}, e);
      end
    end
  end

  initial begin
    bit got;

    // Reset held with busy-looking inputs: every output must read 0.
    reset = 1'b0;
    bus.sched_en      = 1'b1;
    bus.ready_warps   = 4'hF;
    bus.warp_opcode   = 16'hAAAA;
    bus.warp_array_id = 8'hE4;
    bus.warp_mask     = MASKS;
    bus.issue_ready   = 1'b1;
    bus.array_done    = 1'b1;
    bus.array_done_id = 2'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.issue_valid, bus.select_warp, bus.busy_en, bus.warp_num_busy,
           bus.threads_mask_busy, bus.array_busy, bus.push_active}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.ready_warps = 4'h0;
    bus.array_done  = 1'b0;
    bus.warp_opcode = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle_iv_%0d", k), bus.issue_valid, 0);
    end
    @(posedge clk); #1;

    // Round robin, all ready, always accepted.
    add(1,1,4'hF,1,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 1,0,1,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 1,1,1,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 0,1,0,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 1,2,1,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 0,2,0,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 1,3,1,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 0,3,0,4'h0);
    add(0,1,4'hF,1,0,0,16'h0000,8'h00, 1,0,1,4'h0);
    // Backpressure on warp 2 while ready_warps toggles.
    add(1,1,4'h4,0,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,1,4'hB,0,0,0,16'h0000,8'h00, 1,2,0,4'h0);
    add(0,1,4'h0,0,0,0,16'h0000,8'h00, 1,2,0,4'h0);
    add(0,1,4'hF,0,0,0,16'h0000,8'h00, 1,2,0,4'h0);
    add(0,1,4'h0,1,0,0,16'h0000,8'h00, 1,2,1,4'h0);
    add(0,1,4'h0,1,0,0,16'h0000,8'h00, 0,2,0,4'h0);
    // Push lock: warps 0 and 1 push to array 1, warp 3 plain.
    add(1,1,4'h1,1,0,0,16'h00AA,8'h05, 0,0,0,4'h0);
    add(0,1,4'h0,1,0,0,16'h00AA,8'h05, 1,0,1,4'h0);
    add(0,1,4'hA,0,0,0,16'h00AA,8'h05, 0,0,0,4'h2);
    add(0,1,4'h0,1,0,0,16'h00AA,8'h05, 1,3,1,4'h2);
    add(0,1,4'h2,1,1,1,16'h00AA,8'h05, 0,3,0,4'h2);
    add(0,1,4'h2,1,0,0,16'h00AA,8'h05, 0,3,0,4'h0);
    add(0,1,4'h0,1,0,0,16'h00AA,8'h05, 1,1,1,4'h0);
    add(0,1,4'h0,1,0,0,16'h00AA,8'h05, 0,1,0,4'h2);
    // sched_en low: idle in ARB, no retraction in ISSUE, no new grant after.
    add(1,0,4'hF,1,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,0,4'hF,1,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,1,4'h2,0,0,0,16'h0000,8'h00, 0,0,0,4'h0);
    add(0,0,4'h0,0,0,0,16'h0000,8'h00, 1,1,0,4'h0);
    add(0,0,4'h0,1,0,0,16'h0000,8'h00, 1,1,1,4'h0);
    add(0,0,4'hF,1,0,0,16'h0000,8'h00, 0,1,0,4'h0);
    add(0,0,4'hF,1,0,0,16'h0000,8'h00, 0,1,0,4'h0);
    // Same-cycle set/clear on array 2, clear of idle array, blocked push then release.
    add(1,1,4'h4,1,0,0,16'h0A00,8'h20, 0,0,0,4'h0);
    add(0,1,4'h0,1,1,2,16'h0A00,8'h20, 1,2,1,4'h0);
    add(0,1,4'h0,1,1,0,16'h0A00,8'h20, 0,2,0,4'h4);
    add(0,1,4'h0,1,0,0,16'h0A00,8'h20, 0,2,0,4'h4);
    add(0,1,4'h4,1,0,0,16'h0A00,8'h20, 0,2,0,4'h4);
    add(0,1,4'h4,1,1,2,16'h0A00,8'h20, 0,2,0,4'h4);
    add(0,1,4'h4,1,0,0,16'h0A00,8'h20, 0,2,0,4'h0);
    add(0,1,4'h0,1,0,0,16'h0A00,8'h20, 1,2,1,4'h0);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      bus.sched_en      = tv[i].sched;
      bus.ready_warps   = tv[i].rdy;
      bus.issue_ready   = tv[i].ir;
      bus.array_done    = tv[i].done;
      bus.array_done_id = tv[i].did;
      bus.warp_opcode   = tv[i].op;
      bus.warp_array_id = tv[i].aid;
      if (tv[i].e_busy) sb_q.push_back({tv[i].e_sel, mask_of(tv[i].e_sel)});
      @(negedge clk);
      check($sformatf("v%0d_issue_valid", i), bus.issue_valid, tv[i].e_iv);
      check($sformatf("v%0d_select_warp", i), bus.select_warp, tv[i].e_sel);
      check($sformatf("v%0d_busy_en", i), bus.busy_en, tv[i].e_busy);
      check($sformatf("v%0d_array_busy", i), bus.array_busy, tv[i].e_ab);
      check($sformatf("v%0d_push_active", i), bus.push_active, |tv[i].e_ab);
      @(posedge clk); #1;
    end

    // Reset asserted mid-ISSUE: array 2 still owned from the last accepted push.
    bus.ready_warps = 4'h2;
    bus.issue_ready = 1'b0;
    bus.sched_en    = 1'b1;
    bus.array_done  = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (bus.issue_valid === 1'b1) got = 1'b1;
    end
    check("rmi_reached_issue", got, 1);
    check("rmi_select_before", bus.select_warp, 1);
    check("rmi_array_busy_before", bus.array_busy, 4'h4);
    #2;
    reset = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    check("rmi_outputs_after",
          {bus.issue_valid, bus.select_warp, bus.busy_en, bus.warp_num_busy,
           bus.threads_mask_busy, bus.array_busy, bus.push_active}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.ready_warps = 4'h0;
    bus.warp_opcode = 16'h0000;

    // Starve warp 0 seven times, then offer warps 0 and 2 together.
    issue_one(4'h2, 2'd1, "age_seed");
    for (int k = 0; k < 7; k++) begin
      issue_one(4'h5, 2'd2, $sformatf("age_skip_%0d", k));
      issue_one(4'h2, 2'd1, $sformatf("age_fill_%0d", k));
    end
`ifdef WARP_ARB_AGING_EN
    issue_one(4'h5, 2'd0, "age_priority");
`else
    issue_one(4'h5, 2'd2, "rr_no_aging");
`endif

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
